// File: rtl/laser_job_sched.sv
// Job sequencer for the two-circle laser coverage core: arbitrates two point
// requesters, buffers one job, streams it into the core and returns the result.
module laser_job_sched #(
  parameter int unsigned NPTS        = 40,
  parameter int unsigned TIMEOUT_CYC = 32767
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       r0_valid,
  input  logic [3:0] r0_x,
  input  logic [3:0] r0_y,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [3:0] r1_x,
  input  logic [3:0] r1_y,
  output logic       r1_ready,
  output logic       core_rst,
  output logic [3:0] core_x,
  output logic [3:0] core_y,
  input  logic       core_done,
  input  logic [3:0] core_c1x,
  input  logic [3:0] core_c1y,
  input  logic [3:0] core_c2x,
  input  logic [3:0] core_c2y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic       res_err,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic       busy
);

  typedef enum logic [2:0] {
    ARB, LOAD, CRST, STREAM, WAIT, CAPT, RESULT
  } state_t;

  localparam logic [5:0]  LAST_IDX = 6'(NPTS - 1);
  localparam logic [15:0] TMO      = 16'(TIMEOUT_CYC);

  state_t      state, state_nx;
  logic        grant, grant_nx;
  logic        last;
  logic [5:0]  load_cnt;
  logic [5:0]  stream_cnt;
  logic [15:0] wait_cnt;
  logic        rerr;
  logic [3:0]  rc1x, rc1y, rc2x, rc2y;

  logic [3:0]  buf_x [NPTS];
  logic [3:0]  buf_y [NPTS];

  logic        in_valid;
  logic [3:0]  in_x, in_y;
  logic        beat;

  always_comb begin
    in_valid = grant ? r1_valid : r0_valid;
    in_x     = grant ? r1_x     : r0_x;
    in_y     = grant ? r1_y     : r0_y;
    beat     = (state == LOAD) && in_valid;
  end

  // Next-state and grant selection; a tie goes to the requester not served last.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    case (state)
      ARB: begin
        if (r0_valid || r1_valid) begin
          state_nx = LOAD;
          if (r0_valid && r1_valid) grant_nx = ~last;
          else                      grant_nx = r1_valid;
        end
      end
      LOAD:   if (beat && (load_cnt == LAST_IDX)) state_nx = CRST;
      CRST:   state_nx = STREAM;
      STREAM: if (stream_cnt == LAST_IDX) state_nx = WAIT;
      WAIT: begin
        if (core_done)            state_nx = CAPT;
        else if (wait_cnt == TMO) state_nx = RESULT;
      end
      CAPT:   state_nx = RESULT;
      RESULT: if (res_ready) state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ARB;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      if (state == ARB && state_nx == LOAD) last <= grant_nx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_cnt   <= '0;
      stream_cnt <= '0;
      wait_cnt   <= '0;
      rerr       <= 1'b0;
      rc1x       <= '0;
      rc1y       <= '0;
      rc2x       <= '0;
      rc2y       <= '0;
    end else begin
      case (state)
        ARB:  load_cnt <= '0;
        LOAD: if (beat) load_cnt <= load_cnt + 6'd1;
        CRST: stream_cnt <= '0;
        STREAM: begin
          stream_cnt <= stream_cnt + 6'd1;
          wait_cnt   <= '0;
        end
        WAIT: begin
          if (wait_cnt != TMO) wait_cnt <= wait_cnt + 16'd1;
          if (!core_done && wait_cnt == TMO) begin
            rerr <= 1'b1;
            rc1x <= '0;
            rc1y <= '0;
            rc2x <= '0;
            rc2y <= '0;
          end
        end
        CAPT: begin
          rerr <= 1'b0;
          rc1x <= core_c1x;
          rc1y <= core_c1y;
          rc2x <= core_c2x;
          rc2y <= core_c2y;
        end
        default: ;
      endcase
    end
  end

  // Point buffer holds no reset; its contents are only read after a full load.
  always_ff @(posedge CLK) begin
    if (beat) begin
      buf_x[load_cnt] <= in_x;
      buf_y[load_cnt] <= in_y;
    end
  end

  always_comb begin
    r0_ready  = (state == LOAD) && !grant;
    r1_ready  = (state == LOAD) &&  grant;
    core_rst  = !((state == STREAM) || (state == WAIT));
    core_x    = (state == STREAM) ? buf_x[stream_cnt] : '0;
    core_y    = (state == STREAM) ? buf_y[stream_cnt] : '0;
    busy      = (state != ARB);
    res_valid = (state == RESULT);
    res_id    = res_valid && grant;
    res_err   = res_valid && rerr;
    res_c1x   = res_valid ? rc1x : '0;
    res_c1y   = res_valid ? rc1y : '0;
    res_c2x   = res_valid ? rc2x : '0;
    res_c2y   = res_valid ? rc2y : '0;
  end

endmodule

// File: tb/tb_laser_job_sched.sv
// Directed bench for laser_job_sched: a job table exercised end to end plus a
// hand-written reset-during-stream sequence.
module tb_laser_job_sched;

  localparam int NPTS = 40;
  localparam int TMO  = 100;

  logic       CLK = 1'b0;
  logic       RST;
  logic       r0_valid, r1_valid, r0_ready, r1_ready;
  logic [3:0] r0_x, r0_y, r1_x, r1_y;
  logic       core_rst, core_done;
  logic [3:0] core_x, core_y, core_c1x, core_c1y, core_c2x, core_c2y;
  logic       res_valid, res_ready, res_id, res_err, busy;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;

  laser_job_sched #(.NPTS(NPTS), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .r0_valid(r0_valid), .r0_x(r0_x), .r0_y(r0_y), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_x(r1_x), .r1_y(r1_y), .r1_ready(r1_ready),
    .core_rst(core_rst), .core_x(core_x), .core_y(core_y),
    .core_done(core_done),
    .core_c1x(core_c1x), .core_c1y(core_c1y), .core_c2x(core_c2x), .core_c2y(core_c2y),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_err(res_err),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v0;
    logic       v1;
    logic       gap;
    int         done_dly;   // -1: core never signals done
    logic [3:0] c1x, c1y, c2x, c2y;
    int         bp;         // cycles res_ready is held low
    logic       exp_id;
    logic       exp_err;
  } job_t;

  job_t jobs [7];
  int   cnt  [2];
  int   nchecks = 0;
  int   nerrs   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  endtask

  function automatic logic [3:0] px(input int id, input int k);
    return 4'(k + 7 * id);
  endfunction

  function automatic logic [3:0] py(input int k);
    return 4'(15 - k);
  endfunction

  task automatic load_phase(input job_t j, output bit ok);
    int id;
    bit ph;
    id = int'(j.exp_id);
    ph = 1'b1;
    ok = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      r0_valid  = j.v0 & ((j.gap && id == 0) ? ph : 1'b1);
      r1_valid  = j.v1 & ((j.gap && id == 1) ? ph : 1'b1);
      r0_x      = px(0, cnt[0]);
      r0_y      = py(cnt[0]);
      r1_x      = px(1, cnt[1]);
      r1_y      = py(cnt[1]);
      core_done = j.gap & ph;   // stray done pulses outside WAIT must be ignored
      ph        = ~ph;
      chk("load_other_ready", (id == 0) ? r1_ready : r0_ready, 0);
      chk("load_core_rst", core_rst, 1);
      if (id == 0 ? (r0_valid & r0_ready) : (r1_valid & r1_ready)) cnt[id]++;
      @(negedge CLK);
      if (cnt[id] == NPTS) begin
        ok = 1'b1;
        break;
      end
    end
    core_done = 1'b0;
    if (!ok) chk("load_beats", cnt[id], NPTS);
  endtask

  task automatic stream_phase(input job_t j, input int n);
    for (int k = 0; k < n; k++) begin
      chk("stream_core_rst", core_rst, 0);
      chk("stream_ready", r0_ready | r1_ready, 0);
      chk("stream_x", core_x, px(int'(j.exp_id), k));
      chk("stream_y", core_y, py(k));
      @(negedge CLK);
    end
  endtask

  task automatic crst_check(input job_t j);
    chk("crst_core_rst", core_rst, 1);
    chk("crst_busy", busy, 1);
    chk("crst_ready", j.exp_id ? r1_ready : r0_ready, 0);
    @(negedge CLK);
  endtask

  task automatic run_job(input job_t j);
    bit ok;
    int exp_idx;
    logic [15:0] vals;
    vals = {j.c1x, j.c1y, j.c2x, j.c2y};
    load_phase(j, ok);
    if (!ok) finish_now();
    crst_check(j);
    stream_phase(j, NPTS);
    exp_idx = (j.done_dly >= 0) ? j.done_dly + 2 : TMO + 1;
    ok = 1'b0;
    for (int idx = 0; idx < 400; idx++) begin
      if (res_valid) begin
        chk("result_latency", idx, exp_idx);
        ok = 1'b1;
        break;
      end
      chk("wait_core_rst", core_rst, (j.done_dly >= 0 && idx == j.done_dly + 1));
      chk("wait_core_x", core_x, 0);
      core_done = (idx == j.done_dly);
      {core_c1x, core_c1y, core_c2x, core_c2y} =
        (j.done_dly >= 0 && idx == j.done_dly + 1) ? vals : ~vals;
      @(negedge CLK);
    end
    core_done = 1'b0;
    if (!ok) begin
      chk("result_timeout", 0, 1);
      finish_now();
    end
    for (int r = 0; r <= j.bp; r++) begin
      chk("res_valid", res_valid, 1);
      chk("res_id", res_id, j.exp_id);
      chk("res_err", res_err, j.exp_err);
      chk("res_c1x", res_c1x, j.exp_err ? 4'd0 : j.c1x);
      chk("res_c1y", res_c1y, j.exp_err ? 4'd0 : j.c1y);
      chk("res_c2x", res_c2x, j.exp_err ? 4'd0 : j.c2x);
      chk("res_c2y", res_c2y, j.exp_err ? 4'd0 : j.c2y);
      chk("res_core_rst", core_rst, 1);
      chk("res_no_grant", r0_ready | r1_ready, 0);
      {core_c1x, core_c1y, core_c2x, core_c2y} = 16'($urandom);
      if (r == j.bp) res_ready = 1'b1;
      @(negedge CLK);
    end
    res_ready = 1'b0;
    chk("post_res_valid", res_valid, 0);
    chk("post_busy", busy, 0);
    cnt[int'(j.exp_id)] = 0;
  endtask

  initial begin
    #1000000;
    chk("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $fatal(1, "watchdog expired");
  end

  initial begin
    job_t jr;
    bit   ok;

    //            v0    v1    gap   D   c1x   c1y   c2x   c2y   bp  id    err
    jobs[0] = '{1'b1, 1'b1, 1'b0,  3, 4'h1, 4'h2, 4'h3, 4'h4,  0, 1'b0, 1'b0};
    jobs[1] = '{1'b1, 1'b1, 1'b0,  0, 4'h5, 4'h6, 4'h7, 4'h8,  2, 1'b1, 1'b0};
    jobs[2] = '{1'b1, 1'b1, 1'b0,  7, 4'h9, 4'hA, 4'hB, 4'hC,  0, 1'b0, 1'b0};
    jobs[3] = '{1'b1, 1'b1, 1'b0, 12, 4'hD, 4'hE, 4'hF, 4'h0, 10, 1'b1, 1'b0};
    jobs[4] = '{1'b1, 1'b0, 1'b0,  5, 4'h3, 4'hC, 4'hA, 4'h5,  0, 1'b0, 1'b0};
    jobs[5] = '{1'b0, 1'b1, 1'b1,  2, 4'h7, 4'h1, 4'hE, 4'h2, 10, 1'b1, 1'b0};
    jobs[6] = '{1'b1, 1'b0, 1'b0, -1, 4'hF, 4'hF, 4'hF, 4'hF,  0, 1'b0, 1'b1};

    cnt[0] = 0;
    cnt[1] = 0;
    RST = 1'b1;
    {r0_valid, r1_valid, core_done, res_ready} = '0;
    {r0_x, r0_y, r1_x, r1_y} = '0;
    {core_c1x, core_c1y, core_c2x, core_c2y} = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", r0_ready | r1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_res_c", {res_id, res_err, res_c1x, res_c1y, res_c2x, res_c2y}, 0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) run_job(jobs[i]);

    // Reset during stream cycle 20 drops the job; the next tie goes to r0.
    jr = '{1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0, 1'b0};
    load_phase(jr, ok);
    if (!ok) finish_now();
    crst_check(jr);
    stream_phase(jr, 20);
    RST = 1'b1;
    #1;
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_ready", r0_ready | r1_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_core_x", core_x, 0);
    @(negedge CLK);
    RST = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    jr = '{1'b1, 1'b1, 1'b0, 4, 4'h2, 4'h4, 4'h6, 4'h8, 1, 1'b0, 1'b0};
    run_job(jr);

    finish_now();
  end

endmodule

// File: doc/laser_job_sched.md
Name: laser_job_sched

Overview:
- Job sequencer in front of the two-circle laser coverage core.
- Arbitrates between two point-set requesters and buffers one 40-point job.
- Parks the core in reset, then streams the buffered points on 40 back-to-back cycles, which is the core's non-stallable read protocol.
- Waits for the core's done pulse, then returns the two circle centres to the requester with a tag.

Parameters:
NPTS, 40, points per job; must equal the core's read count.
TIMEOUT_CYC, 32767, maximum WAIT cycles before the job is aborted with an error; 16-bit counter.

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
r0_valid  in  1  requester 0 point valid
r0_x  in  4  requester 0 point X
r0_y  in  4  requester 0 point Y
r0_ready  out  1  requester 0 point accepted when valid&ready
r1_valid  in  1  requester 1 point valid
r1_x  in  4  requester 1 point X
r1_y  in  4  requester 1 point Y
r1_ready  out  1  requester 1 point accepted
core_rst  out  1  reset to laser core; active-high
core_x  out  4  point X to core
core_y  out  4  point Y to core
core_done  in  1  core done pulse (1 cycle)
core_c1x  in  4  core circle 1 X
core_c1y  in  4  core circle 1 Y
core_c2x  in  4  core circle 2 X
core_c2y  in  4  core circle 2 Y
res_valid  out  1  result valid; held until res_ready
res_ready  in  1  result consumer ready
res_id  out  1  requester that owns the result
res_err  out  1  1 = job aborted on timeout
res_c1x  out  4  circle 1 X
res_c1y  out  4  circle 1 Y
res_c2x  out  4  circle 2 X
res_c2y  out  4  circle 2 Y
busy  out  1  high in every state except ARB

Behaviour:
- Reset values:
  - State ARB; round-robin pointer last=1, so requester 0 wins first.
  - core_rst=1; every other output 0.
  - Point buffer contents don't-care.
- States: ARB, LOAD, CRST, STREAM, WAIT, CAPT, RESULT.
- ARB:
  - If either rN_valid is high, grant one: on a tie the requester != last wins, otherwise the single valid one.
  - Register grant and set last=grant; go to LOAD.
  - rN_ready=0 in ARB; the first point is not consumed here.
- LOAD:
  - r[grant]_ready=1, the other ready=0.
  - Each valid&ready beat writes buffer[load_cnt] and increments load_cnt (6-bit).
  - Gaps in valid are allowed.
  - On the beat that writes index NPTS-1, go to CRST; ready drops the next cycle.
- CRST: core_rst=1 for exactly 1 cycle; stream_cnt=0.
- STREAM:
  - core_rst=0; core_x/core_y = buffer[stream_cnt] in cycle k=stream_cnt.
  - One point per cycle, no bubbles, indices 0..NPTS-1 in order.
  - After cycle NPTS-1, go to WAIT.
  - core_x/core_y are 0 outside STREAM.
- WAIT:
  - core_rst=0; wait_cnt increments each cycle.
  - core_done=1: go to CAPT (the core's outputs settle one cycle after done).
  - wait_cnt==TIMEOUT_CYC without done: go to RESULT with res_err=1 and coordinates 0.
  - If done and timeout coincide, done wins.
- CAPT:
  - 1 cycle; register core_c1x..core_c2y into res_*; res_err=0.
  - core_rst=1 from this cycle on, which parks the core so it cannot start reading garbage.
- RESULT:
  - res_valid=1 with res_id=grant.
  - res_* are stable while res_valid&!res_ready.
  - On res_valid&res_ready, go to ARB; res_valid=0 the next cycle.
- core_rst is 1 in ARB, LOAD, CRST, CAPT and RESULT; it is 0 only in STREAM and WAIT.
- core_done outside WAIT is ignored.
- busy is 0 only in ARB.
- RST asserted mid-job: every state and counter returns to reset values immediately. The partial job is dropped and no result is produced. core_rst goes to 1 asynchronously.
- Counters never wrap within a job: load_cnt and stream_cnt are bounded by NPTS; wait_cnt saturates at TIMEOUT_CYC.

Test Plan:
- Single job: r0 sends 40 points (k,15-k), k=0..39, with r1 idle -> one 1-cycle core_rst pulse; core_x=k in STREAM cycle k; core_done at cycle D -> res_valid at D+2 with res_id=0, res_err=0 and res_c* equal to the core outputs one cycle after done.
- Contention: r0_valid and r1_valid both high after reset -> jobs are served in order 0,1,0,1 across four jobs; the non-granted ready stays 0 throughout.
- Load gaps: r1_valid toggles every other cycle -> exactly 40 points captured in order; CRST entered only after the 40th beat; STREAM still has no bubbles.
- Result backpressure: res_ready held 0 for 10 cycles -> res_valid and res_* stable for those 10 cycles; no new grant until acceptance; core_rst=1 throughout.
- Timeout: TIMEOUT_CYC=100 with core_done tied 0 -> res_valid with res_err=1, all coordinates 0, 101 cycles after WAIT entry; core_rst returns to 1.
- Reset mid-STREAM: RST pulsed at stream cycle 20 -> core_rst=1, ready=0, res_valid=0 immediately; the next job is granted to requester 0 and completes normally.
